// File: rtl/rans_pkg.sv
// Shared types and helpers for the rANS lane scheduler.
package rans_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_FREQ,
        S_FLUSH,
        S_DRAIN
    } sched_state_t;

    // Width of a lane index; at least one bit even for a single lane.
    function automatic int unsigned lane_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rans_lane_sched_if.sv
// Host-side bundle of the scheduler: symbol/freq-write input, flush/done and merged output stream.
interface rans_lane_sched_if #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned SYMBOL_WIDTH = 8,
    parameter int unsigned RESOLUTION   = 10,
    parameter int unsigned ENC_WIDTH    = 8
) ();

    localparam int unsigned NW = $clog2(NUM_LANES) + 1;
    localparam int unsigned IW = rans_pkg::lane_idx_w(NUM_LANES);

    logic [NW-1:0]           num_lanes_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [SYMBOL_WIDTH-1:0] symb_i;
    logic                    freq_wr_i;
    logic [RESOLUTION-1:0]   freq_i;
    logic [RESOLUTION-1:0]   cum_freq_i;
    logic                    flush_i;
    logic                    done_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [ENC_WIDTH-1:0]    out_enc_o;
    logic [IW-1:0]           out_lane_o;

    // Host / producer side.
    modport master (
        output num_lanes_i, in_valid_i, symb_i, freq_wr_i, freq_i, cum_freq_i, flush_i,
               out_ready_i,
        input  in_ready_o, done_o, out_valid_o, out_enc_o, out_lane_o
    );

    // Scheduler side.
    modport slave (
        input  num_lanes_i, in_valid_i, symb_i, freq_wr_i, freq_i, cum_freq_i, flush_i,
               out_ready_i,
        output in_ready_o, done_o, out_valid_o, out_enc_o, out_lane_o
    );

endinterface

// File: rtl/rans_lane_fifo.sv
// Per-lane synchronous output FIFO with show-ahead read data.
module rans_lane_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             full, do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= ovf_q | (push && !do_push);
        end
    end

    // A dropped word means the issue throttle failed to leave enough room.
    ovf_never: assert property (@(posedge clk) disable iff (rst) !ovf_q);

endmodule

// File: rtl/rans_lane_sched.sv
// Round-robin symbol issue, freq-table broadcast, flush sequencing and output merge for rANS lanes.
module rans_lane_sched
    import rans_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned SYMBOL_WIDTH = 8,
    parameter int unsigned RESOLUTION   = 10,
    parameter int unsigned ENC_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned MAX_EMIT     = 2,
    parameter int unsigned FREQ_WR_CYC  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    rans_lane_sched_if.slave               host,
    output logic [NUM_LANES-1:0]           lane_en_o,
    output logic [SYMBOL_WIDTH-1:0]        lane_symb_o,
    output logic [NUM_LANES-1:0]           lane_flush_o,
    output logic                           lane_freq_wr_o,
    output logic [RESOLUTION-1:0]          freq_o,
    output logic [RESOLUTION-1:0]          cum_freq_o,
    input  logic [NUM_LANES-1:0]           lane_valid_i,
    input  logic [NUM_LANES*ENC_WIDTH-1:0] lane_enc_i,
    input  logic [NUM_LANES-1:0]           lane_busy_i
);

    localparam int unsigned IW = lane_idx_w(NUM_LANES);
    localparam int unsigned NW = $clog2(NUM_LANES) + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = $clog2(FREQ_WR_CYC) + 1;
    localparam logic [CW-1:0] ROOM_MAX  = CW'(FIFO_DEPTH - MAX_EMIT);
    localparam logic [NW-1:0] LANES_MAX = NW'(NUM_LANES);
    localparam logic [FW-1:0] FREQ_LAST = FW'(FREQ_WR_CYC - 1);

    sched_state_t            state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d, flush_idx_q, flush_idx_d;
    logic [NW-1:0]           active_q, active_d, nl_sat, active_eff;
    logic [FW-1:0]           freq_cnt_q, freq_cnt_d;
    logic [NUM_LANES-1:0]    lane_en_q, lane_en_d, lane_flush_q, lane_flush_d;
    logic [SYMBOL_WIDTH-1:0] lane_symb_q, lane_symb_d;
    logic                    lane_freq_wr_q, lane_freq_wr_d, done_q, done_d;
    logic [RESOLUTION-1:0]   freq_q, freq_d, cum_freq_q, cum_freq_d;
    logic                    room, in_ready, accept, drain_ok;

    logic [NUM_LANES-1:0]    fifo_pop, fifo_empty;
    logic [ENC_WIDTH-1:0]    fifo_rdata [NUM_LANES];
    logic [CW-1:0]           fifo_count [NUM_LANES];
    logic                    out_valid_q, load, sel_found;
    logic [ENC_WIDTH-1:0]    out_enc_q;
    logic [IW-1:0]           out_lane_q, last_q, sel_idx, cand;

    // Lane count request, saturating out-of-range values to the physical count.
    always_comb begin
        nl_sat = host.num_lanes_i;
        if (nl_sat == '0 || nl_sat > LANES_MAX) nl_sat = LANES_MAX;
        active_eff = (state_q == S_RUN && ptr_q == '0) ? nl_sat : active_q;
    end

    // Throttle: every active lane must still have room for a worst-case emit.
    always_comb begin
        room = 1'b1;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (NW'(l) < active_q && fifo_count[l] > ROOM_MAX) room = 1'b0;
        end
    end

    assign in_ready        = (state_q == S_RUN) && !host.freq_wr_i && !host.flush_i && room;
    assign accept          = host.in_valid_i && in_ready;
    assign drain_ok        = (lane_busy_i == '0) && (&fifo_empty);
    assign host.in_ready_o = in_ready;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (host.freq_wr_i)    state_d = S_FREQ;
                else if (host.flush_i) state_d = S_FLUSH;
            end
            S_FREQ:  if (freq_cnt_q == FREQ_LAST) state_d = S_RUN;
            S_FLUSH: if (NW'(flush_idx_q) == active_q - NW'(1)) state_d = S_DRAIN;
            S_DRAIN: if (drain_ok) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // FSM outputs and datapath next values; every lane-facing output is registered.
    always_comb begin
        lane_en_d      = '0;
        lane_flush_d   = '0;
        lane_freq_wr_d = 1'b0;
        done_d         = 1'b0;
        lane_symb_d    = lane_symb_q;
        freq_d         = freq_q;
        cum_freq_d     = cum_freq_q;
        ptr_d          = ptr_q;
        active_d       = active_q;
        freq_cnt_d     = freq_cnt_q;
        flush_idx_d    = flush_idx_q;
        unique case (state_q)
            S_RUN: begin
                if (ptr_q == '0) active_d = nl_sat;
                if (host.freq_wr_i) begin
                    lane_freq_wr_d = 1'b1;
                    lane_symb_d    = host.symb_i;
                    freq_d         = host.freq_i;
                    cum_freq_d     = host.cum_freq_i;
                    freq_cnt_d     = '0;
                end else if (host.flush_i) begin
                    flush_idx_d = '0;
                end else if (accept) begin
                    lane_en_d   = NUM_LANES'(1) << ptr_q;
                    lane_symb_d = host.symb_i;
                    ptr_d = (NW'(ptr_q) == active_eff - NW'(1)) ? '0 : ptr_q + IW'(1);
                end
            end
            S_FREQ: freq_cnt_d = freq_cnt_q + FW'(1);
            S_FLUSH: begin
                lane_flush_d = NUM_LANES'(1) << flush_idx_q;
                flush_idx_d  = flush_idx_q + IW'(1);
            end
            S_DRAIN: begin
                if (drain_ok) begin
                    done_d = 1'b1;
                    ptr_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Scheduler datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q          <= '0;
            active_q       <= LANES_MAX;
            freq_cnt_q     <= '0;
            flush_idx_q    <= '0;
            lane_en_q      <= '0;
            lane_flush_q   <= '0;
            lane_freq_wr_q <= 1'b0;
            lane_symb_q    <= '0;
            freq_q         <= '0;
            cum_freq_q     <= '0;
            done_q         <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            active_q       <= active_d;
            freq_cnt_q     <= freq_cnt_d;
            flush_idx_q    <= flush_idx_d;
            lane_en_q      <= lane_en_d;
            lane_flush_q   <= lane_flush_d;
            lane_freq_wr_q <= lane_freq_wr_d;
            lane_symb_q    <= lane_symb_d;
            freq_q         <= freq_d;
            cum_freq_q     <= cum_freq_d;
            done_q         <= done_d;
        end
    end

    assign lane_en_o      = lane_en_q;
    assign lane_flush_o   = lane_flush_q;
    assign lane_freq_wr_o = lane_freq_wr_q;
    assign lane_symb_o    = lane_symb_q;
    assign freq_o         = freq_q;
    assign cum_freq_o     = cum_freq_q;
    assign host.done_o    = done_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_fifo
        rans_lane_fifo #(
            .WIDTH (ENC_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .push  (lane_valid_i[l]),
            .pop   (fifo_pop[l]),
            .wdata (lane_enc_i[l*ENC_WIDTH +: ENC_WIDTH]),
            .rdata (fifo_rdata[l]),
            .empty (fifo_empty[l]),
            .count (fifo_count[l])
        );
    end

    // Merge arbiter: first non-empty FIFO after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_LANES);
            if (!sel_found && !fifo_empty[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // The output register refills whenever it is empty or being consumed.
    assign load     = !out_valid_q || host.out_ready_i;
    assign fifo_pop = (load && sel_found) ? (NUM_LANES'(1) << sel_idx) : '0;

    // Merged output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_enc_q   <= '0;
            out_lane_q  <= '0;
            last_q      <= IW'(NUM_LANES - 1);
        end else if (load) begin
            out_valid_q <= sel_found;
            if (sel_found) begin
                out_enc_q  <= fifo_rdata[sel_idx];
                out_lane_q <= sel_idx;
                last_q     <= sel_idx;
            end
        end
    end

    assign host.out_valid_o = out_valid_q;
    assign host.out_enc_o   = out_enc_q;
    assign host.out_lane_o  = out_lane_q;

endmodule

// File: tb/tb_rans_lane_sched.sv
// Directed bench for rans_lane_sched with issue/flush/output scoreboards.
module tb_rans_lane_sched;

    localparam int unsigned NL = 4;
    localparam int unsigned SW = 8;
    localparam int unsigned RW = 10;
    localparam int unsigned EW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rans_lane_sched_if #(
        .NUM_LANES    (NL),
        .SYMBOL_WIDTH (SW),
        .RESOLUTION   (RW),
        .ENC_WIDTH    (EW)
    ) bus ();

    logic [NL-1:0]    lane_en, lane_flush, lane_valid, lane_busy;
    logic [SW-1:0]    lane_symb;
    logic             lane_freq_wr;
    logic [RW-1:0]    freq, cum;
    logic [NL*EW-1:0] lane_enc;

    rans_lane_sched #(
        .NUM_LANES    (NL),
        .SYMBOL_WIDTH (SW),
        .RESOLUTION   (RW),
        .ENC_WIDTH    (EW),
        .FIFO_DEPTH   (8),
        .MAX_EMIT     (2),
        .FREQ_WR_CYC  (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host           (bus),
        .lane_en_o      (lane_en),
        .lane_symb_o    (lane_symb),
        .lane_flush_o   (lane_flush),
        .lane_freq_wr_o (lane_freq_wr),
        .freq_o         (freq),
        .cum_freq_o     (cum),
        .lane_valid_i   (lane_valid),
        .lane_enc_i     (lane_enc),
        .lane_busy_i    (lane_busy)
    );

    logic [NL+SW-1:0] en_q [$];
    logic [NL-1:0]    fl_q [$];
    logic [2+EW-1:0]  out_q [$];
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture pre-edge handshake state, then check scoreboards after the edge.
    task automatic tick();
        logic fire, stall, rst_pre;
        logic [EW-1:0] enc_pre;
        logic [1:0] lane_pre;
        logic [NL+SW-1:0] en_exp;
        logic [2+EW-1:0] out_exp;
        fire     = (bus.out_valid_o && bus.out_ready_i) === 1'b1;
        stall    = (bus.out_valid_o && !bus.out_ready_i) === 1'b1;
        rst_pre  = rst;
        enc_pre  = bus.out_enc_o;
        lane_pre = bus.out_lane_o;
        @(posedge clk);
        #1;
        if (fire) begin
            if (out_q.size() == 0) check("out_unexpected", 32'(lane_pre), 32'hFFFF);
            else begin
                out_exp = out_q.pop_front();
                check("out_lane", 32'(lane_pre), 32'(out_exp[EW +: 2]));
                check("out_enc", 32'(enc_pre), 32'(out_exp[EW-1:0]));
            end
        end
        if (stall && !rst_pre) begin
            check("stall_valid", 32'(bus.out_valid_o), 32'd1);
            check("stall_enc", 32'(bus.out_enc_o), 32'(enc_pre));
            check("stall_lane", 32'(bus.out_lane_o), 32'(lane_pre));
        end
        if (lane_en !== '0) begin
            if (en_q.size() == 0) check("en_unexpected", 32'(lane_en), 32'd0);
            else begin
                en_exp = en_q.pop_front();
                check("lane_en", 32'(lane_en), 32'(en_exp[SW +: NL]));
                check("lane_symb", 32'(lane_symb), 32'(en_exp[SW-1:0]));
            end
        end
        if (lane_flush !== '0) begin
            if (fl_q.size() == 0) check("flush_unexpected", 32'(lane_flush), 32'd0);
            else check("lane_flush", 32'(lane_flush), 32'(fl_q.pop_front()));
        end
        if (bus.done_o === 1'b1) done_cnt++;
    endtask

    initial begin
        int exp_cnt;
        rst = 1'b1;
        bus.num_lanes_i = 3'd4;
        bus.in_valid_i = 1'b0;
        bus.symb_i = '0;
        bus.freq_wr_i = 1'b0;
        bus.freq_i = '0;
        bus.cum_freq_i = '0;
        bus.flush_i = 1'b0;
        bus.out_ready_i = 1'b0;
        lane_valid = '0;
        lane_enc = '0;
        lane_busy = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_lane_en", 32'(lane_en), 32'd0);
        check("rst_lane_flush", 32'(lane_flush), 32'd0);
        check("rst_freq_wr", 32'(lane_freq_wr), 32'd0);
        check("rst_lane_symb", 32'(lane_symb), 32'd0);
        check("rst_freq", 32'(freq), 32'd0);
        check("rst_cum", 32'(cum), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_out_enc", 32'(bus.out_enc_o), 32'd0);
        check("rst_out_lane", 32'(bus.out_lane_o), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Eight back-to-back symbols over four lanes.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid_i = 1'b1;
            bus.symb_i = SW'(32'h10 + i);
            #1;
            check("in_ready_run", 32'(bus.in_ready_o), 32'd1);
            en_q.push_back({NL'(1) << (i % 4), SW'(32'h10 + i)});
            tick();
        end
        bus.in_valid_i = 1'b0;
        tick();
        check("issue_all_seen", 32'(en_q.size()), 32'd0);

        // Lanes 0 and 3 together, output stalled for a few cycles.
        lane_valid = 4'b1001;
        lane_enc = {8'hD3, 8'h00, 8'h00, 8'hA0};
        out_q.push_back({2'd0, 8'hA0});
        out_q.push_back({2'd3, 8'hD3});
        tick();
        lane_valid = '0;
        tick();
        check("merge_first_lane", 32'(bus.out_lane_o), 32'd0);
        check("merge_first_enc", 32'(bus.out_enc_o), 32'hA0);
        tick();
        tick();
        bus.out_ready_i = 1'b1;
        repeat (4) tick();
        check("merge_all_seen", 32'(out_q.size()), 32'd0);

        // Frequency-table write with a competing symbol.
        bus.freq_wr_i = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.symb_i = 8'h41;
        bus.freq_i = 10'h020;
        bus.cum_freq_i = 10'h100;
        #1;
        check("in_ready_fwr", 32'(bus.in_ready_o), 32'd0);
        tick();
        check("fwr_strobe", 32'(lane_freq_wr), 32'd1);
        check("fwr_addr", 32'(lane_symb), 32'h41);
        check("fwr_freq", 32'(freq), 32'h020);
        check("fwr_cum", 32'(cum), 32'h100);
        bus.freq_wr_i = 1'b0;
        bus.in_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("in_ready_freq_hold", 32'(bus.in_ready_o), 32'd0);
            tick();
            if (k == 0) check("fwr_one_cycle", 32'(lane_freq_wr), 32'd0);
        end
        #1;
        check("in_ready_after_freq", 32'(bus.in_ready_o), 32'd1);

        // Three active lanes, six symbols, then flush with a blocked symbol.
        bus.num_lanes_i = 3'd3;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid_i = 1'b1;
            bus.symb_i = SW'(32'h60 + i);
            en_q.push_back({NL'(1) << (i % 3), SW'(32'h60 + i)});
            tick();
        end
        bus.symb_i = 8'hEE;
        bus.flush_i = 1'b1;
        lane_busy = 4'b0111;
        #1;
        check("in_ready_flush", 32'(bus.in_ready_o), 32'd0);
        fl_q.push_back(4'b0001);
        fl_q.push_back(4'b0010);
        fl_q.push_back(4'b0100);
        tick();
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        repeat (3) tick();
        check("flush_all_seen", 32'(fl_q.size()), 32'd0);
        lane_valid = 4'b0010;
        lane_enc = '0;
        lane_enc[1*EW +: EW] = 8'h5A;
        out_q.push_back({2'd1, 8'h5A});
        tick();
        lane_valid = '0;
        repeat (3) tick();
        check("no_done_while_busy", 32'(done_cnt), 32'd0);
        lane_busy = '0;
        repeat (8) tick();
        check("done_once", 32'(done_cnt), 32'd1);
        check("drain_out_seen", 32'(out_q.size()), 32'd0);
        check("issue3_all_seen", 32'(en_q.size()), 32'd0);
        check("in_ready_after_done", 32'(bus.in_ready_o), 32'd1);

        // Lane 2 fills its FIFO against a stalled output.
        bus.num_lanes_i = 3'd4;
        bus.out_ready_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            lane_valid = 4'b0100;
            lane_enc = '0;
            lane_enc[2*EW +: EW] = EW'(32'hC0 + n - 1);
            out_q.push_back({2'd2, EW'(32'hC0 + n - 1)});
            tick();
            // First word moves into the output register one edge after it lands.
            exp_cnt = (n <= 1) ? n : n - 1;
            check("in_ready_fill", 32'(bus.in_ready_o), (exp_cnt <= 6) ? 32'd1 : 32'd0);
        end
        lane_valid = '0;
        tick();
        check("in_ready_full", 32'(bus.in_ready_o), 32'd0);
        check("fill_out_lane", 32'(bus.out_lane_o), 32'd2);
        bus.out_ready_i = 1'b1;
        repeat (10) tick();
        check("fill_all_seen", 32'(out_q.size()), 32'd0);
        check("in_ready_drained", 32'(bus.in_ready_o), 32'd1);

        // Reset while draining with data still buffered.
        bus.out_ready_i = 1'b0;
        lane_valid = 4'b0010;
        lane_enc = '0;
        lane_enc[1*EW +: EW] = 8'h77;
        tick();
        lane_enc[1*EW +: EW] = 8'h78;
        tick();
        lane_valid = '0;
        bus.flush_i = 1'b1;
        lane_busy = 4'b1111;
        fl_q.push_back(4'b0001);
        fl_q.push_back(4'b0010);
        fl_q.push_back(4'b0100);
        fl_q.push_back(4'b1000);
        tick();
        bus.flush_i = 1'b0;
        repeat (5) tick();
        check("flush4_all_seen", 32'(fl_q.size()), 32'd0);
        check("no_done_before_rst", 32'(done_cnt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_drain_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_drain_in_ready", 32'(bus.in_ready_o), 32'd1);
        bus.in_valid_i = 1'b1;
        bus.symb_i = 8'h99;
        en_q.push_back({4'b0001, 8'h99});
        tick();
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) tick();
        check("rst_fifo_discarded", 32'(bus.out_valid_o), 32'd0);
        check("rst_ptr_zero_seen", 32'(en_q.size()), 32'd0);
        check("no_done_after_rst", 32'(done_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
